ppu_fb_writer: RTL and testbench

Downstream consumer of the PPU pixel stream. Accepts 2-bit colour indices from the PPU background FIFO (`PX_OUT`/`PX_valid`) and optionally maps them through BGP. Packs four pixels per byte and writes each byte to the 160x144 frame buffer RAM through a small FIFO with ready back-pressure. Tracks column position per scanline, pads partial bytes at line end, and flags dropped data.

---
 rtl/ppu_pkg.sv | 22 ++
 rtl/ppu_fb_fifo.sv | 46 ++++
 rtl/ppu_fb_writer.sv | 126 ++++++++++++
 tb/tb_ppu_fb_writer.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ppu_pkg.sv
// Shared PPU definitions: mode encodings, LCD geometry and frame-writer FSM states.
// Pure declarations; no latency and no backpressure.
package ppu_pkg;

  typedef enum logic [1:0] {
    H_BLANK = 2'd0,
    V_BLANK = 2'd1,
    SCAN    = 2'd2,
    DRAW    = 2'd3
  } ppu_mode_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DRAIN  = 2'd2
  } frame_state_e;

  localparam logic [7:0] LCD_W             = 8'd160;
  localparam logic [7:0] LCD_H             = 8'd144;
  localparam logic [7:0] FB_BYTES_PER_LINE = 8'd40;

endpackage

// File: rtl/ppu_fb_fifo.sv
// Synchronous FIFO, head visible combinationally; push-to-head latency one cycle.
// A push into a full FIFO is taken only when a pop happens on the same edge.
module ppu_fb_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         do_pop;
  logic         do_push;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr[AW-1:0]];

  // Storage is cleared on reset so the head reads zero out of reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr[AW-1:0]] <= din;
        wr_ptr              <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/ppu_fb_writer.sv
// Packs PPU pixels four per byte into frame-buffer writes (BGP mapping under PPU_FB_PALETTE_EN).
// Byte visible one cycle after its 4th pixel; fb_ready stalls the FIFO head, overflow drops and flags.
module ppu_fb_writer
  import ppu_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int FB_AW      = 13
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       px_in,
  input  logic             px_valid,
  input  logic [1:0]       ppu_mode,
  input  logic [7:0]       ly,
  input  logic [7:0]       bgp,
  output logic             fb_wr_en,
  output logic [FB_AW-1:0] fb_addr,
  output logic [7:0]       fb_data,
  input  logic             fb_ready,
  output logic             frame_done,
  output logic             px_drop,
  output logic             fifo_ovf
);

  ppu_mode_e    mode_cur;
  ppu_mode_e    mode_q;
  frame_state_e state_q;
  frame_state_e state_d;

  logic             draw_enter, draw_exit, vblank_enter, in_draw;
  logic [7:0]       x_q, x_eff;
  logic [7:0]       pack_q, pack_next;
  logic [1:0]       shade, k;
  logic             px_ok, accept, reject, byte_done, flush, push_req, ovf_evt;
  logic [FB_AW-1:0] ly_w, line_base, wr_addr;
  logic [FB_AW+7:0] push_dat, head;
  logic             full, empty;
  logic             unused_bgp;

  assign mode_cur   = ppu_mode_e'(ppu_mode);
  assign unused_bgp = ^bgp;

  always_comb begin
    in_draw      = (mode_cur == DRAW);
    draw_enter   = in_draw && (mode_q != DRAW);
    draw_exit    = (mode_q == DRAW) && !in_draw;
    vblank_enter = (mode_cur == V_BLANK) && (mode_q != V_BLANK);
    // A pixel on the DRAW-entry cycle is column 0 of the new line.
    x_eff        = draw_enter ? 8'd0 : x_q;
    px_ok        = (x_eff < LCD_W) && (ly < LCD_H);
    accept       = px_valid && in_draw && px_ok;
    reject       = px_valid && in_draw && !px_ok;
    k            = x_eff[1:0];
`ifdef PPU_FB_PALETTE_EN
    shade        = bgp[{px_in, 1'b0} +: 2];
`else
    shade        = px_in;
`endif
    // First pixel of a byte lands in the MSBs: shift by 2*(3-k).
    pack_next    = pack_q | (8'(shade) << {~k, 1'b0});
    byte_done    = accept && (k == 2'd3);
    flush        = draw_exit && (x_q[1:0] != 2'd0);
    push_req     = byte_done || flush;
    ly_w         = FB_AW'(ly);
    line_base    = (ly_w << 5) + (ly_w << 3);
    wr_addr      = line_base + FB_AW'(x_eff[7:2]);
    push_dat     = {wr_addr, (byte_done ? pack_next : pack_q)};
    ovf_evt      = push_req && full && !fb_ready;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q   <= H_BLANK;
      x_q      <= 8'd0;
      pack_q   <= 8'd0;
      px_drop  <= 1'b0;
      fifo_ovf <= 1'b0;
    end else begin
      mode_q <= mode_cur;
      if (accept)          x_q <= x_eff + 8'd1;
      else if (draw_enter) x_q <= 8'd0;
      if (push_req)        pack_q <= 8'd0;
      else if (accept)     pack_q <= pack_next;
      if (reject)  px_drop  <= 1'b1;
      if (ovf_evt) fifo_ovf <= 1'b1;
    end
  end

  ppu_fb_fifo #(
    .W     (FB_AW + 8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_req),
    .din   (push_dat),
    .pop   (fb_ready),
    .full  (full),
    .empty (empty),
    .head  (head)
  );

  assign fb_wr_en = !empty;
  assign fb_addr  = head[FB_AW+7:8];
  assign fb_data  = head[7:0];

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (draw_enter && (ly == 8'd0)) state_d = ACTIVE;
      ACTIVE:  if (vblank_enter)               state_d = DRAIN;
      DRAIN:   if (empty)                      state_d = IDLE;
      default:                                 state_d = IDLE;
    endcase
  end

  always_comb begin
    frame_done = (state_q == DRAIN) && empty;
  end

endmodule

// File: tb/tb_ppu_fb_writer.sv
// Randomized and directed bench for ppu_fb_writer against a queue-based reference model.
module tb_ppu_fb_writer;
  import ppu_pkg::*;

  localparam int DEPTH = 4;
  localparam int AW    = 13;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [1:0]    px_in = 2'd0;
  logic          px_valid = 1'b0;
  logic [1:0]    ppu_mode = 2'd0;
  logic [7:0]    ly = 8'd0;
  logic [7:0]    bgp = 8'hE4;
  logic          fb_ready = 1'b0;
  logic          fb_wr_en;
  logic [AW-1:0] fb_addr;
  logic [7:0]    fb_data;
  logic          frame_done;
  logic          px_drop;
  logic          fifo_ovf;

  ppu_fb_writer #(.FIFO_DEPTH(DEPTH), .FB_AW(AW)) dut (
    .clk(clk), .rst(rst), .px_in(px_in), .px_valid(px_valid), .ppu_mode(ppu_mode),
    .ly(ly), .bgp(bgp), .fb_wr_en(fb_wr_en), .fb_addr(fb_addr), .fb_data(fb_data),
    .fb_ready(fb_ready), .frame_done(frame_done), .px_drop(px_drop), .fifo_ovf(fifo_ovf)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: frame-buffer writes as a bounded queue, line pixels as a list.
  logic [20:0] mq[$];
  int          line_px[$];
  bit          m_drop, m_ovf;
  logic [1:0]  m_prev;
  int          m_phase;
  bit          chk_en = 1'b0;
  bit          rnd_ready = 1'b0;
  logic [20:0] wr_log[$];
  int          fd_count = 0;

  function automatic logic [1:0] map_px(logic [1:0] idx, logic [7:0] pal);
    logic [7:0] t;
    t = pal >> (2 * idx);
`ifdef PPU_FB_PALETTE_EN
    return t[1:0];
`else
    return idx;
`endif
  endfunction

  function automatic void m_emit(int base, int cnt, int lyv);
    logic [7:0]  d;
    logic [12:0] a;
    d = 8'd0;
    for (int j = 0; j < cnt; j++) d |= 8'(line_px[base + j]) << (6 - 2 * j);
    a = 13'(lyv * 40 + base / 4);
    if (mq.size() < DEPTH) mq.push_back({a, d});
    else m_ovf = 1'b1;
  endfunction

  always @(posedge clk) begin
    int sz0;
    bit enter, leave;
    if (rst) begin
      mq.delete();
      line_px.delete();
      m_drop  = 1'b0;
      m_ovf   = 1'b0;
      m_prev  = 2'd0;
      m_phase = 0;
    end else begin
      sz0   = mq.size();
      enter = (ppu_mode == 2'd3) && (m_prev != 2'd3);
      leave = (m_prev == 2'd3) && (ppu_mode != 2'd3);
      if (fb_ready && sz0 > 0) void'(mq.pop_front());
      if (enter) line_px.delete();
      if (ppu_mode == 2'd3 && px_valid) begin
        if (line_px.size() < 160 && ly < 144) begin
          line_px.push_back(int'(map_px(px_in, bgp)));
          if (line_px.size() % 4 == 0) m_emit(line_px.size() - 4, 4, int'(ly));
        end else begin
          m_drop = 1'b1;
        end
      end
      if (leave && (line_px.size() % 4 != 0))
        m_emit(line_px.size() - line_px.size() % 4, line_px.size() % 4, int'(ly));
      case (m_phase)
        0: if (enter && ly == 8'd0) m_phase = 1;
        1: if (ppu_mode == 2'd1 && m_prev != 2'd1) m_phase = 2;
        2: if (sz0 == 0) m_phase = 0;
        default: m_phase = 0;
      endcase
      m_prev = ppu_mode;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check_eq("wr_en", 32'(fb_wr_en), 32'(mq.size() > 0));
      if (mq.size() > 0) begin
        check_eq("addr", 32'(fb_addr), 32'(mq[0][20:8]));
        check_eq("data", 32'(fb_data), 32'(mq[0][7:0]));
      end
      check_eq("frame_done", 32'(frame_done), 32'(m_phase == 2 && mq.size() == 0));
      check_eq("px_drop", 32'(px_drop), 32'(m_drop));
      check_eq("fifo_ovf", 32'(fifo_ovf), 32'(m_ovf));
      if (!rst && fb_wr_en && fb_ready) wr_log.push_back({fb_addr, fb_data});
      if (frame_done) fd_count++;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
    if (rnd_ready) fb_ready = ($urandom_range(0, 9) < 7);
  endtask

  task automatic enter_draw(input logic [7:0] l);
    px_valid = 1'b0;
    ly       = l;
    ppu_mode = SCAN;
    cyc();
    ppu_mode = DRAW;
    cyc();
  endtask

  task automatic pixel(input logic [1:0] p);
    px_valid = 1'b1;
    px_in    = p;
    cyc();
    px_valid = 1'b0;
  endtask

  task automatic leave_draw();
    px_valid = 1'b0;
    ppu_mode = H_BLANK;
    cyc();
  endtask

  logic [1:0] pat [8] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd2, 2'd1, 2'd0};
  int         log0, fd0, n;

  initial begin
    cyc();
    chk_en = 1'b1;
    cyc();
    check_eq("rst_wr_en", 32'(fb_wr_en), 0);
    check_eq("rst_addr", 32'(fb_addr), 0);
    check_eq("rst_data", 32'(fb_data), 0);
    check_eq("rst_frame_done", 32'(frame_done), 0);
    check_eq("rst_px_drop", 32'(px_drop), 0);
    check_eq("rst_fifo_ovf", 32'(fifo_ovf), 0);
    rst = 1'b0;
    cyc();

    // Eight pixels on line 0 with the RAM always ready.
    bgp      = 8'h1B;
    fb_ready = 1'b1;
    log0     = wr_log.size();
    enter_draw(8'd0);
    for (int i = 0; i < 8; i++) begin
      pixel(pat[i]);
      if (i == 3) check_eq("latency_wr_en", 32'(fb_wr_en), 1);
    end
    leave_draw();
    repeat (3) cyc();
    check_eq("l0_count", wr_log.size() - log0, 2);
`ifdef PPU_FB_PALETTE_EN
    check_eq("l0_w0", 32'(wr_log[log0]), {13'h0000, 8'hE4});
    check_eq("l0_w1", 32'(wr_log[log0 + 1]), {13'h0001, 8'h1B});
`else
    check_eq("l0_w0", 32'(wr_log[log0]), {13'h0000, 8'h1B});
    check_eq("l0_w1", 32'(wr_log[log0 + 1]), {13'h0001, 8'hE4});
`endif

    // Last visible line, partial byte flushed at DRAW exit.
    bgp  = 8'hE4;
    log0 = wr_log.size();
    enter_draw(8'd143);
    repeat (6) pixel(2'd3);
    leave_draw();
    repeat (3) cyc();
    check_eq("l143_count", wr_log.size() - log0, 2);
    check_eq("l143_w0", 32'(wr_log[log0]), {13'(143 * 40), 8'hFF});
    check_eq("l143_w1", 32'(wr_log[log0 + 1]), {13'(143 * 40 + 1), 8'hF0});

    // 20 bytes against a stalled RAM: only the FIFO's worth survives.
    fb_ready = 1'b0;
    enter_draw(8'd5);
    for (int i = 0; i < 80; i++) pixel(2'(i));
    leave_draw();
    cyc();
    check_eq("ovf_flag", 32'(fifo_ovf), 1);
    check_eq("ovf_held", 32'(fb_addr), 200);
    log0     = wr_log.size();
    fb_ready = 1'b1;
    repeat (8) cyc();
    check_eq("ovf_count", wr_log.size() - log0, DEPTH);
    for (int i = 0; i < DEPTH; i++)
      check_eq("ovf_order", 32'(wr_log[log0 + i]), {13'(200 + i), 8'h1B});

    // 161 pixels on one line.
    check_eq("drop_before", 32'(px_drop), 0);
    log0 = wr_log.size();
    enter_draw(8'd10);
    for (int i = 0; i < 161; i++) pixel(2'($urandom_range(0, 3)));
    leave_draw();
    repeat (3) cyc();
    check_eq("line161_count", wr_log.size() - log0, 40);
    check_eq("line161_drop", 32'(px_drop), 1);

    // V_BLANK entry with two bytes queued, RAM ready pulsed.
    fb_ready = 1'b0;
    enter_draw(8'd20);
    for (int i = 0; i < 8; i++) pixel(pat[i]);
    leave_draw();
    ppu_mode = V_BLANK;
    cyc();
    fd0 = fd_count;
    check_eq("drain_not_done", 32'(frame_done), 0);
    for (int i = 0; i < 12; i++) begin
      fb_ready = (i % 3 == 0);
      cyc();
    end
    fb_ready = 1'b0;
    repeat (2) cyc();
    check_eq("frame_done_pulses", fd_count - fd0, 1);

    // Reset with three bytes queued.
    enter_draw(8'd0);
    for (int i = 0; i < 12; i++) pixel(2'($urandom_range(0, 3)));
    cyc();
    check_eq("prerst_wr_en", 32'(fb_wr_en), 1);
    rst      = 1'b1;
    fb_ready = 1'b1;
    cyc();
    check_eq("rst_mid_wr_en", 32'(fb_wr_en), 0);
    rst      = 1'b0;
    ppu_mode = H_BLANK;
    log0     = wr_log.size();
    repeat (10) cyc();
    check_eq("post_rst_writes", wr_log.size() - log0, 0);
    check_eq("post_rst_drop", 32'(px_drop), 0);
    check_eq("post_rst_ovf", 32'(fifo_ovf), 0);

    // Random frames with random RAM backpressure.
    rnd_ready = 1'b1;
    for (int f = 0; f < 3; f++) begin
      for (int ln = 0; ln < 6; ln++) begin
        bgp = 8'($urandom);
        enter_draw(ln == 0 ? 8'd0 : 8'($urandom_range(0, 153)));
        n = $urandom_range(0, 170);
        for (int i = 0; i < n; i++) begin
          if ($urandom_range(0, 3) == 0) cyc();
          pixel(2'($urandom_range(0, 3)));
        end
        leave_draw();
        repeat ($urandom_range(0, 3)) cyc();
      end
      ppu_mode = V_BLANK;
      repeat (30) cyc();
    end
    rnd_ready = 1'b0;
    cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
